// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_pkg
// Purpose  : Shared types and constants for the memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } mem_owner_t;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_watchdog
// Purpose  : Transaction age counter; expire flags the TIMEOUT-th busy cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int              C_CNT_W = $clog2(TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT - 1);

    logic [C_CNT_W-1:0] r_cnt;

    // Holds at the last value so expire stays asserted until the owner leaves.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en & (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and load/store, one
//            outstanding transaction, with stall generation and watchdog.
//            Define MEM_ARB_RR_EN for round-robin arbitration on conflict.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            dm_read_en_i,
    input  logic            dm_write_en_i,
    input  logic [XLEN-1:0] dm_addr_i,
    input  logic [XLEN-1:0] dm_wdata_i,
    input  logic [1:0]      dm_size_i,
    output logic            dm_gnt_o,
    output logic            dm_rvalid_o,
    output logic [XLEN-1:0] dm_rdata_o,
    output logic            halt_o,
    output logic            bus_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [1:0]      mem_size_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    mem_arb_state_t  r_state;
    mem_arb_state_t  w_state_nxt;
    mem_owner_t      r_owner;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [1:0]      r_mem_size;

    logic            w_dm_req;
    logic            w_any_req;
    logic            w_pick_dm;
    logic            w_launch;
    logic            w_done_rd;
    logic            w_done_wr;
    logic            w_abort;
    logic            w_expire;
    logic            w_rvalid;
    logic [XLEN-1:0] w_rdata;
    logic            w_dm_done;

    assign w_dm_req  = dm_read_en_i | dm_write_en_i;
    assign w_any_req = w_dm_req | if_req_i;

`ifdef MEM_ARB_RR_EN
    mem_owner_t r_prio;
    logic       w_conflict;

    assign w_conflict = w_dm_req & if_req_i;
    assign w_pick_dm  = w_dm_req & (~if_req_i | (r_prio == OWN_DM));

    // Only contested grants move the pointer, toward the loser.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_prio <= OWN_DM;
        end else if (w_launch && w_conflict) begin
            r_prio <= w_pick_dm ? OWN_IF : OWN_DM;
        end
    end
`else
    assign w_pick_dm = w_dm_req;
`endif

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .i_clr    (r_state == IDLE),
        .i_en     (r_state != IDLE),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A completion in the expiry cycle takes precedence over the abort.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done_rd   = 1'b0;
        w_done_wr   = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_launch    = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i && r_mem_we) begin
                    w_done_wr   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (mem_gnt_i && mem_rvalid_i) begin
                    w_done_rd   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (mem_gnt_i) begin
                    w_state_nxt = WAIT_R;
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    w_done_rd   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expire) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_owner     <= OWN_DM;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
        end else begin
            r_mem_req <= w_launch | ((r_state == REQ) && (w_state_nxt == REQ));
            if (w_launch) begin
                r_owner     <= w_pick_dm ? OWN_DM : OWN_IF;
                r_mem_we    <= w_pick_dm & dm_write_en_i;
                r_mem_addr  <= w_pick_dm ? dm_addr_i  : if_addr_i;
                r_mem_wdata <= w_pick_dm ? dm_wdata_i : '0;
                r_mem_size  <= w_pick_dm ? dm_size_i  : MEM_SIZE_W;
            end
        end
    end

    // Aborted reads still return a response so the requester is released.
    assign w_rvalid  = w_done_rd | (w_abort & ~r_mem_we);
    assign w_rdata   = w_done_rd ? mem_rdata_i : '0;
    assign w_dm_done = (r_owner == OWN_DM) & (w_done_rd | w_done_wr | w_abort);

    assign if_gnt_o    = w_launch & ~w_pick_dm;
    assign dm_gnt_o    = w_launch &  w_pick_dm;
    assign if_rvalid_o = w_rvalid & (r_owner == OWN_IF);
    assign dm_rvalid_o = w_rvalid & (r_owner == OWN_DM);
    assign if_rdata_o  = if_rvalid_o ? w_rdata : '0;
    assign dm_rdata_o  = dm_rvalid_o ? w_rdata : '0;
    assign halt_o      = w_dm_req & ~w_dm_done;
    assign bus_err_o   = w_abort;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_size_o  = r_mem_size;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_gnt, if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            dm_read, dm_write;
    logic [XLEN-1:0] dm_addr, dm_wdata;
    logic [1:0]      dm_size;
    logic            dm_gnt, dm_rvalid;
    logic [XLEN-1:0] dm_rdata;
    logic            halt, bus_err;
    logic            mem_req, mem_we;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic [1:0]      mem_size;
    logic            mem_gnt, mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .if_req_i      (if_req),
        .if_addr_i     (if_addr),
        .if_gnt_o      (if_gnt),
        .if_rvalid_o   (if_rvalid),
        .if_rdata_o    (if_rdata),
        .dm_read_en_i  (dm_read),
        .dm_write_en_i (dm_write),
        .dm_addr_i     (dm_addr),
        .dm_wdata_i    (dm_wdata),
        .dm_size_i     (dm_size),
        .dm_gnt_o      (dm_gnt),
        .dm_rvalid_o   (dm_rvalid),
        .dm_rdata_o    (dm_rdata),
        .halt_o        (halt),
        .bus_err_o     (bus_err),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_size_o    (mem_size),
        .mem_gnt_i     (mem_gnt),
        .mem_rvalid_i  (mem_rvalid),
        .mem_rdata_i   (mem_rdata)
    );

    typedef struct packed {
        logic            ig;
        logic            dg;
        logic            ir;
        logic            dr;
        logic            be;
        logic [XLEN-1:0] d;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs;
    ev_t front;
    int  errors = 0;
    int  checks = 0;

    function automatic ev_t mk(input logic ig, input logic dg, input logic ir,
                               input logic dr, input logic be, input logic [XLEN-1:0] d);
        ev_t e;
        e.ig = ig;
        e.dg = dg;
        e.ir = ir;
        e.dr = dr;
        e.be = be;
        e.d  = d;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        dm_read    = 1'b0;
        dm_write   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Any grant/response/error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        obs = mk(if_gnt, dm_gnt, if_rvalid, dm_rvalid, bus_err, if_rdata | dm_rdata);
        if (obs.ig | obs.dg | obs.ir | obs.dr | obs.be) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %h expected none", obs);
            end else begin
                front = exp_q.pop_front();
                chk("event", 64'(obs), 64'(front));
            end
        end
    end

    initial begin
        resetn   = 1'b0;
        idle_inputs();
        if_addr  = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_size  = '0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_size",  mem_size,  0);
        chk("rst_halt",      halt,      0);
        cyc();
        resetn = 1'b1;

        // Fetch read: gnt two cycles later, data two cycles after that.
        cyc(); if_req = 1; if_addr = 32'h100; exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        mid(); chk("t1_halt_idle", halt, 0);
        cyc(); if_req = 0;
        mid(); chk("t1_mem_req", mem_req, 1); chk("t1_addr", mem_addr, 32'h100);
               chk("t1_size", mem_size, 2'b10); chk("t1_we", mem_we, 0); chk("t1_halt_req", halt, 0);
        cyc(); mem_gnt = 1;
        mid(); chk("t1_halt_gnt", halt, 0);
        cyc(); mem_gnt = 0;
        mid(); chk("t1_req_waitr", mem_req, 0); chk("t1_halt_waitr", halt, 0);
        cyc(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; exp_q.push_back(mk(0, 0, 1, 0, 0, 32'hDEADBEEF));
        mid(); chk("t1_halt_rv", halt, 0);
        cyc(); idle_inputs();

        // Conflict: data side first, fetch granted in the following IDLE cycle.
        cyc(); if_req = 1; if_addr = 32'h400; dm_read = 1; dm_addr = 32'h200; dm_size = 2'b10;
               exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
        mid(); chk("t2_halt_idle", halt, 1);
        cyc(); mem_gnt = 1;
        mid(); chk("t2_addr", mem_addr, 32'h200); chk("t2_halt_req", halt, 1);
        cyc(); mem_gnt = 0;
        mid(); chk("t2_halt_waitr", halt, 1);
        cyc(); mem_rvalid = 1; mem_rdata = 32'hCAFEF00D; exp_q.push_back(mk(0, 0, 0, 1, 0, 32'hCAFEF00D));
        mid(); chk("t2_halt_done", halt, 0);
        cyc(); mem_rvalid = 0; dm_read = 0; exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        mid(); chk("t2_halt_after", halt, 0);
        cyc(); if_req = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h11112222;
               exp_q.push_back(mk(0, 0, 1, 0, 0, 32'h11112222));
        mid(); chk("t2_if_addr", mem_addr, 32'h400);
        cyc(); idle_inputs();

        // Store word, memory accepts on the third REQ cycle.
        cyc(); dm_write = 1; dm_addr = 32'h300; dm_wdata = 32'h12345678; dm_size = 2'b10;
               exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
        mid(); chk("t3_halt_idle", halt, 1);
        cyc();
        mid(); chk("t3_we", mem_we, 1); chk("t3_size", mem_size, 2'b10);
               chk("t3_wdata", mem_wdata, 32'h12345678); chk("t3_addr", mem_addr, 32'h300);
               chk("t3_halt_req1", halt, 1);
        cyc();
        mid(); chk("t3_halt_req2", halt, 1);
        cyc(); mem_gnt = 1;
        mid(); chk("t3_halt_gnt", halt, 0);
        cyc(); mem_gnt = 0; dm_write = 0;
        mid(); chk("t3_req_idle", mem_req, 0);

        // Watchdog abort on a data read that is never granted.
        cyc(); dm_read = 1; dm_addr = 32'h500; exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc();
            mid(); chk("t4_halt_wait", halt, 1); chk("t4_req_wait", mem_req, 1);
        end
        cyc(); exp_q.push_back(mk(0, 0, 0, 1, 1, 0));
        mid(); chk("t4_halt_abort", halt, 0);
        cyc(); dm_read = 0; mem_rvalid = 1; mem_rdata = 32'h00000BAD;
        mid(); chk("t4_req_low", mem_req, 0); chk("t4_stray_rv", dm_rvalid, 0);
        cyc(); idle_inputs();

        // Completion landing on the expiry cycle beats the abort.
        cyc(); if_req = 1; if_addr = 32'h700; exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        cyc(); if_req = 0;
        for (int i = 2; i < TIMEOUT; i++) cyc();
        cyc(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5A5A5;
               exp_q.push_back(mk(0, 0, 1, 0, 0, 32'hA5A5A5A5));
        mid(); chk("t4b_berr", bus_err, 0);
        cyc(); idle_inputs();
        mid(); chk("t4b_req_low", mem_req, 0);

        // Reset while waiting for read data; late data must be dropped.
        cyc(); dm_read = 1; dm_addr = 32'h600; exp_q.push_back(mk(0, 1, 0, 0, 0, 0));
        cyc(); mem_gnt = 1;
        cyc(); mem_gnt = 0;
        mid(); chk("t5_req_waitr", mem_req, 0); chk("t5_halt_waitr", halt, 1);
        cyc(); resetn = 0; dm_read = 0;
        mid(); chk("t5_rst_halt", halt, 0); chk("t5_rst_addr", mem_addr, 0);
               chk("t5_rst_req", mem_req, 0); chk("t5_rst_berr", bus_err, 0);
        cyc(); resetn = 1; mem_rvalid = 1; mem_rdata = 32'h00000077;
        mid(); chk("t5_late_dm_rv", dm_rvalid, 0); chk("t5_late_dm_rd", dm_rdata, 0);
               chk("t5_late_if_rv", if_rvalid, 0);
        cyc(); idle_inputs();

        // Both requesters held: fixed priority keeps DM, round-robin alternates.
        cyc(); if_req = 1; dm_read = 1; if_addr = 32'h800; dm_addr = 32'h900;
        for (int k = 0; k < 4; k++) begin
            logic dm_win;
            dm_win = RR ? ((k % 2) == 0) : 1'b1;
            exp_q.push_back(mk(~dm_win, dm_win, 0, 0, 0, 0));
            mid(); chk("t6_halt_idle", halt, 1);
            cyc(); mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h1000 + k;
                   exp_q.push_back(mk(0, 0, ~dm_win, dm_win, 0, 32'h1000 + k));
            mid(); chk("t6_addr", mem_addr, dm_win ? 32'h900 : 32'h800);
                   chk("t6_halt_req", halt, dm_win ? 0 : 1);
            cyc(); mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        end
        idle_inputs();

        repeat (4) cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port between instruction fetch and the execute stage's load/store path. Arbitrates between the two requesters, sequences one outstanding transaction at a time through a request/grant/read-valid handshake, and routes responses back to the owner. Drives the pipeline halt while a data access is pending. Aborts hung transactions with a watchdog.

## Interface
- XLEN, 32, address/data width (`XLEN)
- TIMEOUT, 16, max cycles a transaction may wait in REQ or WAIT_R before abort (≥2)
- clk_i  in  1  system clock
- resetn_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch read request; held until if_gnt_o
- if_addr_i  in  XLEN  fetch address
- if_gnt_o  out  1  one-cycle pulse: fetch request latched
- if_rvalid_o  out  1  one-cycle pulse: fetch data valid
- if_rdata_o  out  XLEN  fetch read data
- dm_read_en_i / dm_write_en_i  in  1  data load/store request; held until completion; never both set
- dm_addr_i  in  XLEN  data address
- dm_wdata_i  in  XLEN  store data, already right-aligned
- dm_size_i  in  2  00 byte, 01 half, 10 word
- dm_gnt_o  out  1  one-cycle pulse: data request latched
- dm_rvalid_o  out  1  one-cycle pulse: load data valid
- dm_rdata_o  out  XLEN  load data
- halt_o  out  1  pipeline stall (combinational)
- bus_err_o  out  1  one-cycle pulse: watchdog abort
- mem_req_o, mem_we_o  out  1  memory request, write flag (registered)
- mem_addr_o, mem_wdata_o  out  XLEN  registered address, store data
- mem_size_o  out  2  registered size
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  read data valid this cycle
- mem_rdata_i  in  XLEN  read data

## Operation
- FSM states IDLE, REQ, WAIT_R. Owner register: IF or DM.
- IDLE: if any request, select winner, pulse its gnt, latch addr/wdata/size/we/owner into mem_* registers, go REQ. No request: stay.
- REQ: mem_req_o=1. On mem_gnt_i: write → complete, IDLE; read with mem_rvalid_i same cycle → deliver, IDLE; read otherwise → WAIT_R.
- WAIT_R: on mem_rvalid_i, pulse owner's rvalid with rdata = mem_rdata_i, go IDLE.
- mem_rvalid_i outside REQ/WAIT_R is ignored. if_/dm_rdata_o are 0 when not valid.
- halt_o = (dm_read_en_i | dm_write_en_i) & ~dm_done, where dm_done = DM write accepted (REQ & mem_gnt_i) or DM read delivered. The pipeline advances on the edge after completion. The new instruction's request is seen in IDLE next cycle, with no re-grant of the old one.
- Watchdog: counter clears on entry to REQ and counts in REQ and WAIT_R. At TIMEOUT-1 with no completion: pulse bus_err_o. For reads, pulse owner rvalid with rdata 0; for writes, treat as done. Drop mem_req_o, go IDLE. A completion in the same cycle wins over the abort.
- Priority (default): DM beats IF on conflict.

## Timing
- Reset: state IDLE, owner DM, all outputs 0, counter 0, priority pointer DM. mem_req_o drops asynchronously.
- Request seen in IDLE cycle N: gnt pulse in N, mem_req_o high from N+1.
- Minimum write: 2 cycles (request to IDLE). Minimum read: 2 cycles with same-cycle gnt+rvalid.
- A new transaction can start in the cycle after returning to IDLE, so there is at most one outstanding transaction.
- Reset mid-transaction abandons it. No response is emitted, and late mem_rvalid_i is ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflict. The pointer flips to the non-winning requester after each conflicting grant. Non-conflicting grants do not move it.
- Undefined: fixed priority, DM over IF. The pointer logic is absent.

## Structure
- Shared package riscv_mem_pkg: mem_arb_state_t (IDLE, REQ, WAIT_R), mem_owner_t (OWN_IF, OWN_DM), size constants MEM_SIZE_B/H/W.
- Sub-module mem_arb_watchdog: counter with clear, enable and TIMEOUT parameter, outputting the expire pulse.

## Test plan
- Fetch read 0x100, mem_gnt_i at cycle+2, mem_rvalid_i at cycle+4 with 0xDEADBEEF → if_rvalid_o one pulse, data 0xDEADBEEF, halt_o never high.
- Simultaneous if_req_i and dm_read_en_i at 0x200 → dm_gnt_o first, halt_o high until dm_rvalid_o, then fetch granted in the cycle after IDLE.
- Store word 0x12345678 to 0x300, gnt after 3 cycles → mem_we_o=1, mem_size_o=10, halt_o falls in the gnt cycle, no rvalid pulse.
- No mem_gnt_i for TIMEOUT=16 cycles on a DM read → bus_err_o pulse, dm_rvalid_o with 0, mem_req_o low, IDLE.
- Assert resetn_i low while in WAIT_R, then mem_rvalid_i after release → all outputs 0, no rvalid pulse.
- With MEM_ARB_RR_EN, both requesters continuously asserted → grants alternate DM, IF, DM, IF.
